// File: rtl/rns_ewise_stream_alu.sv
// rns_ewise_stream_alu
// Streaming element-wise modular ALU for RNS polynomials. One command per
// polynomial, NBEATS = NSLOTS/LANES operand beats, each of LANES slots x
// NPRIMES residues, pushed through a two-stage pipeline with valid/ready
// flow control on both operand input and result output.
// Optional feature: define RNS_EWISE_MUL_EN to build the MUL datapath. In the
// default build, mode 10 raises cmd_err and the polynomial runs as PASSA.
module rns_ewise_stream_alu #(
  parameter int W       = 32,
  parameter int NPRIMES = 4,
  parameter int NSLOTS  = 16,
  parameter int LANES   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_mode,
  input  logic [NPRIMES*W-1:0]       moduli,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*NPRIMES*W-1:0] in_a,
  input  logic [LANES*NPRIMES*W-1:0] in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*NPRIMES*W-1:0] out_data,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output logic                       cmd_err
);

  localparam int NBEATS = NSLOTS / LANES;
  localparam int CW     = $clog2(NBEATS + 1);
  localparam int NE     = LANES * NPRIMES;
  localparam int W1     = W + 1;
  localparam int W2     = 2 * W;
`ifdef RNS_EWISE_MUL_EN
  localparam int SW     = W2;
`else
  localparam int SW     = W1;
`endif

  if (NSLOTS % LANES != 0) begin : g_bad_cfg
    $fatal(1, "rns_ewise_stream_alu: NSLOTS must be a multiple of LANES");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;
  typedef enum logic [1:0] {
    MODE_ADD   = 2'b00,
    MODE_SUB   = 2'b01,
    MODE_MUL   = 2'b10,
    MODE_PASSA = 2'b11
  } mode_t;

  state_t                       r_state;
  mode_t                        r_mode;
  logic [NPRIMES-1:0][W-1:0]    r_q;
  logic [CW-1:0]                r_in_cnt;
  logic [CW-1:0]                r_out_cnt;
  logic                         r_cmd_err;
  logic                         r_s1_valid;
  logic [NE-1:0][SW-1:0]        r_s1_raw;
  logic                         r_s2_valid;
  logic [NE-1:0][W-1:0]         r_s2_data;

  logic [NE-1:0][W-1:0]         w_a;
  logic [NE-1:0][W-1:0]         w_b;
  logic [NE-1:0][SW-1:0]        w_s1_next;
  logic [NE-1:0][W-1:0]         w_s2_next;
  logic                         w_adv;
  logic                         w_in_fire;
  logic                         w_out_fire;

  assign w_a        = in_a;
  assign w_b        = in_b;
  // The whole pipe moves together; a held output beat freezes both stages.
  assign w_adv      = !r_s2_valid || out_ready;
  assign in_ready   = (r_state == ST_RUN) && w_adv && (r_in_cnt < CW'(NBEATS));
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_s2_valid && out_ready;

  assign cmd_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign cmd_err    = r_cmd_err;
  assign out_valid  = r_s2_valid;
  assign out_data   = r_s2_data;
  assign out_last   = r_s2_valid && (r_out_cnt == CW'(NBEATS - 1));

  // Command FSM, mode/moduli latch and the independent beat counters.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_mode    <= MODE_ADD;
      r_q       <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_cmd_err <= 1'b0;
    end else begin
      r_cmd_err <= 1'b0;
      if (w_in_fire)  r_in_cnt  <= r_in_cnt + 1'b1;
      if (w_out_fire) r_out_cnt <= r_out_cnt + 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_state   <= ST_RUN;
            r_q       <= moduli;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
`ifdef RNS_EWISE_MUL_EN
            r_mode    <= mode_t'(cmd_mode);
`else
            r_mode    <= (cmd_mode == MODE_MUL) ? MODE_PASSA : mode_t'(cmd_mode);
            r_cmd_err <= (cmd_mode == MODE_MUL);
`endif
          end
        end
        ST_RUN: begin
          if (w_in_fire && (r_in_cnt == CW'(NBEATS - 1))) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_out_fire && (r_out_cnt == CW'(NBEATS - 1))) r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Stage-1 combinational: raw sum / borrow-tagged difference / product.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    w_s1_next = '0;
    for (int e = 0; e < NE; e++) begin
      case (r_mode)
        MODE_ADD: w_s1_next[e] = SW'(W1'(w_a[e]) + W1'(w_b[e]));
        MODE_SUB: w_s1_next[e] = SW'(W1'(w_a[e]) - W1'(w_b[e]));
`ifdef RNS_EWISE_MUL_EN
        MODE_MUL: w_s1_next[e] = SW'(W2'(w_a[e]) * W2'(w_b[e]));
`endif
        default:  w_s1_next[e] = SW'(w_a[e]);
      endcase
    end
  end

  // Stage-2 combinational: modular reduction of the stage-1 raw value.
  // SUB keeps the borrow in bit W; adding q wraps the W-bit difference back into range.
  always_comb begin
    w_s2_next = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int p = 0; p < NPRIMES; p++) begin
        case (r_mode)
          MODE_ADD:
            w_s2_next[l*NPRIMES+p] = (r_s1_raw[l*NPRIMES+p][W:0] >= W1'(r_q[p]))
                                   ? W'(r_s1_raw[l*NPRIMES+p][W:0] - W1'(r_q[p]))
                                   : r_s1_raw[l*NPRIMES+p][W-1:0];
          MODE_SUB:
            w_s2_next[l*NPRIMES+p] = r_s1_raw[l*NPRIMES+p][W]
                                   ? r_s1_raw[l*NPRIMES+p][W-1:0] + r_q[p]
                                   : r_s1_raw[l*NPRIMES+p][W-1:0];
`ifdef RNS_EWISE_MUL_EN
          MODE_MUL:
            w_s2_next[l*NPRIMES+p] = W'(r_s1_raw[l*NPRIMES+p] % W2'(r_q[p]));
`endif
          default:
            w_s2_next[l*NPRIMES+p] = r_s1_raw[l*NPRIMES+p][W-1:0];
        endcase
      end
    end
  end

  // Pipeline registers: both stages load only when the pipe advances.
  // NOTE: datapath registers are reset too, since out_data must read 0 out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_raw   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
    end else if (w_adv) begin
      r_s1_valid <= w_in_fire;
      if (w_in_fire)  r_s1_raw  <= w_s1_next;
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_s2_data <= w_s2_next;
    end
  end

endmodule
